// File: rtl/spi_flash_responder_if.sv
// Pin and image-RAM bundle between the Caravel flash master, the flash
// responder and the firmware-image RAM.
`timescale 1ns/1ps
interface spi_flash_responder_if #(
    parameter int MEM_AW = 12
);
    logic              flash_csb;
    logic              flash_clk;
    logic              flash_io0;
    logic              flash_io1;
    logic              flash_io1_oe;
    logic              mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              busy;
    logic [15:0]       rd_cmd_cnt;

    // Responder side: pins and RAM read data in, MISO and RAM request out
    modport slave (
        input  flash_csb, flash_clk, flash_io0, mem_rdata,
        output flash_io1, flash_io1_oe, mem_rd, mem_addr, busy, rd_cmd_cnt
    );

    // Flash master plus image RAM side
    modport master (
        output flash_csb, flash_clk, flash_io0, mem_rdata,
        input  flash_io1, flash_io1_oe, mem_rd, mem_addr, busy, rd_cmd_cnt
    );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI flash emulator for the Caravel housekeeping flash master. Decodes
// single-IO READ (0x03) with a 24-bit address and streams bytes from the
// local image RAM with auto-increment; every other opcode (0xAB included)
// is accepted silently and the bus is left undriven until csb rises.
`timescale 1ns/1ps
module spi_flash_responder #(
    parameter int MEM_AW  = 12,
    parameter int SYNC_FF = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    spi_flash_responder_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [SYNC_FF-1:0] r_csb_sync;
    logic [SYNC_FF-1:0] r_sclk_sync;
    logic [SYNC_FF-1:0] r_io0_sync;
    logic               r_sclk_prev;
    logic               w_csb;
    logic               w_sclk;
    logic               w_io0;
    logic               w_rise;
    logic               w_fall;
    logic [22:0]        r_shift;
    logic [23:0]        w_shift_in;
    logic [4:0]         r_bit_cnt;
    logic [7:0]         r_tx_byte;
    logic [7:0]         r_nxt_byte;
    logic               r_rdv;
    logic               r_dst_nxt;
    logic               r_first;
    logic               r_io1;
    logic               r_oe;
    logic               r_mem_rd;
    logic [MEM_AW-1:0]  r_mem_addr;
    logic [15:0]        r_rd_cmd_cnt;
    logic               w_cmd_done;
    logic               w_addr_done;
    logic               w_unused_addr_hi;

    assign w_csb       = r_csb_sync[SYNC_FF-1];
    assign w_sclk      = r_sclk_sync[SYNC_FF-1];
    assign w_io0       = r_io0_sync[SYNC_FF-1];
    assign w_rise      = w_sclk & ~r_sclk_prev;
    assign w_fall      = ~w_sclk & r_sclk_prev;
    assign w_shift_in  = {r_shift, w_io0};
    assign w_cmd_done  = (r_state == S_CMD)  && w_rise && (r_bit_cnt == 5'd7);
    assign w_addr_done = (r_state == S_ADDR) && w_rise && (r_bit_cnt == 5'd23);
    // Flash address bits above the image RAM width are deliberately dropped
    assign w_unused_addr_hi = ^w_shift_in[23:MEM_AW];

    // Synchronise the three master pins; csb idles high so its chain resets to 1
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_csb_sync  <= '1;
            r_sclk_sync <= '0;
            r_io0_sync  <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_csb_sync  <= {r_csb_sync[SYNC_FF-2:0], bus.flash_csb};
            r_sclk_sync <= {r_sclk_sync[SYNC_FF-2:0], bus.flash_clk};
            r_io0_sync  <= {r_io0_sync[SYNC_FF-2:0], bus.flash_io0};
            r_sclk_prev <= w_sclk;
        end
    end

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state decode; a high csb wins over any coincident clock edge
    always_comb begin
        w_next = r_state;
        if (w_csb) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_CMD;
                // 0xAB (release power-down) needs no reply, so it shares IGNORE
                S_CMD:   if (w_cmd_done) w_next = (w_shift_in[7:0] == 8'h03) ? S_ADDR : S_IGNORE;
                S_ADDR:  if (w_addr_done) w_next = S_DATA;
                default: w_next = r_state;
            endcase
        end
    end

    // Shift-in, RAM prefetch/refill and MISO shift-out datapath
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_tx_byte    <= '0;
            r_nxt_byte   <= '0;
            r_rdv        <= 1'b0;
            r_dst_nxt    <= 1'b0;
            r_first      <= 1'b0;
            r_io1        <= 1'b0;
            r_oe         <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_rd_cmd_cnt <= '0;
        end else begin
            r_mem_rd <= 1'b0;
            // RAM data is valid in the cycle after the strobe cycle
            r_rdv    <= r_mem_rd;
            if (w_csb) begin
                r_bit_cnt <= '0;
                r_oe      <= 1'b0;
                r_rdv     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: r_bit_cnt <= '0;
                    S_CMD, S_ADDR: begin
                        if (w_rise) begin
                            r_shift   <= w_shift_in[22:0];
                            r_bit_cnt <= (w_cmd_done || w_addr_done) ? 5'd0 : r_bit_cnt + 5'd1;
                            if (w_addr_done) begin
                                r_mem_addr   <= w_shift_in[MEM_AW-1:0];
                                r_mem_rd     <= 1'b1;
                                r_dst_nxt    <= 1'b0;
                                r_first      <= 1'b1;
                                r_rd_cmd_cnt <= r_rd_cmd_cnt + 16'd1;
                            end
                        end
                    end
                    S_DATA: begin
                        // First returned byte goes to tx and triggers the
                        // prefetch of the following byte; later ones refill nxt
                        if (r_rdv) begin
                            if (!r_dst_nxt) begin
                                r_tx_byte  <= bus.mem_rdata;
                                r_mem_addr <= r_mem_addr + 1'b1;
                                r_mem_rd   <= 1'b1;
                                r_dst_nxt  <= 1'b1;
                            end else begin
                                r_nxt_byte <= bus.mem_rdata;
                            end
                        end
                        if (w_fall) begin
                            r_oe      <= 1'b1;
                            r_first   <= 1'b0;
                            r_bit_cnt <= (r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd0 && !r_first) begin
                                r_io1      <= r_nxt_byte[7];
                                r_tx_byte  <= {r_nxt_byte[6:0], 1'b0};
                                r_mem_addr <= r_mem_addr + 1'b1;
                                r_mem_rd   <= 1'b1;
                            end else begin
                                r_io1      <= r_tx_byte[7];
                                r_tx_byte  <= {r_tx_byte[6:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.flash_io1    = r_io1;
    assign bus.flash_io1_oe = r_oe;
    assign bus.mem_rd       = r_mem_rd;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.busy         = ~w_csb & (r_state != S_IDLE);
    assign bus.rd_cmd_cnt   = r_rd_cmd_cnt;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: acts as the Caravel flash master
// (flash_clk = clock/8) and as the synchronous image RAM.
`timescale 1ns/1ps
module tb_spi_flash_responder;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   rd_pulses;
    int   oe_clks;
    int   snap_rd;
    int   snap_oe;
    time  t_io1;
    logic [7:0] ram [0:4095];
    logic [7:0] rx_buf [0:7];
    logic [7:0] rx;
    logic       miso;

    spi_flash_responder_if #(.MEM_AW(12)) bus ();

    spi_flash_responder #(.MEM_AW(12), .SYNC_FF(2)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous image RAM: data one clock after the strobe
    always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];

    // Activity counters and last MISO change time
    always @(posedge clk) begin
        if (bus.mem_rd)       rd_pulses <= rd_pulses + 1;
        if (bus.flash_io1_oe) oe_clks   <= oe_clks + 1;
    end
    always @(bus.flash_io1) t_io1 = $time;

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCLK period: low half, sample MISO at the rise, high half, fall
    task automatic spi_bit(input logic mosi, output logic so);
        bus.flash_io0 = mosi;
        wait_clks(4);
        if (bus.flash_io1_oe)
            check("miso_setup", (($time - t_io1) >= 10) ? 32'd1 : 32'd0, 32'd1);
        so = bus.flash_io1;
        bus.flash_clk = 1'b1;
        wait_clks(4);
        bus.flash_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rb);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rb[i] = b;
        end
    endtask

    task automatic start_tx();
        bus.flash_csb = 1'b0;
        wait_clks(2);
    endtask

    task automatic end_tx();
        bus.flash_csb = 1'b1;
        wait_clks(4);
    endtask

    // READ header then n bytes received into rx_buf; csb left low
    task automatic spi_read(input logic [23:0] addr, input int n);
        logic [7:0] d;
        start_tx();
        spi_byte(8'h03, d);
        spi_byte(addr[23:16], d);
        spi_byte(addr[15:8], d);
        spi_byte(addr[7:0], d);
        for (int k = 0; k < n; k++) begin
            spi_byte(8'h00, d);
            rx_buf[k] = d;
        end
    endtask

    initial begin
        tests = 0; fails = 0; rd_pulses = 0; oe_clks = 0; t_io1 = 0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h010] = 8'hDE; ram[12'h011] = 8'hAD; ram[12'h012] = 8'hBE; ram[12'h013] = 8'hEF;
        ram[12'hFFF] = 8'h5A; ram[12'h000] = 8'hA5;
        ram[12'h004] = 8'h3C; ram[12'h020] = 8'h77;
        rst = 1'b1;
        bus.flash_csb = 1'b1;
        bus.flash_clk = 1'b0;
        bus.flash_io0 = 1'b0;
        wait_clks(3);

        // Reset state
        check("rst_io1",  bus.flash_io1, 0);
        check("rst_oe",   bus.flash_io1_oe, 0);
        check("rst_rd",   bus.mem_rd, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cnt",  bus.rd_cmd_cnt, 0);
        rst = 1'b0;
        wait_clks(3);

        // READ 0x000010, four bytes
        spi_read(24'h000010, 4);
        check("t1_b0", rx_buf[0], 8'hDE);
        check("t1_b1", rx_buf[1], 8'hAD);
        check("t1_b2", rx_buf[2], 8'hBE);
        check("t1_b3", rx_buf[3], 8'hEF);
        check("t1_oe",   bus.flash_io1_oe, 1);
        check("t1_busy", bus.busy, 1);
        check("t1_cnt",  bus.rd_cmd_cnt, 1);
        end_tx();
        check("t1_oe_off", bus.flash_io1_oe, 0);
        check("t1_idle",   bus.busy, 0);

        // Address wrap at the top of the image RAM
        spi_read(24'h000FFF, 2);
        check("t2_b0", rx_buf[0], 8'h5A);
        check("t2_b1", rx_buf[1], 8'hA5);
        check("t2_cnt", bus.rd_cmd_cnt, 2);
        end_tx();

        // 0xAB then 0x9F + 24 clocks: no drive, no RAM reads
        snap_rd = rd_pulses;
        snap_oe = oe_clks;
        start_tx();
        spi_byte(8'hAB, rx);
        check("t3_busy_ign", bus.busy, 1);
        end_tx();
        start_tx();
        spi_byte(8'h9F, rx);
        for (int k = 0; k < 3; k++) spi_byte(8'h00, rx);
        end_tx();
        check("t3_oe_cnt", oe_clks - snap_oe, 0);
        check("t3_rd_cnt", rd_pulses - snap_rd, 0);
        check("t3_cnt", bus.rd_cmd_cnt, 2);

        // Abort after 03 00, then READ 0x000004
        snap_rd = rd_pulses;
        start_tx();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        check("t4_busy_mid", bus.busy, 1);
        bus.flash_csb = 1'b1;
        wait_clks(3);
        check("t4_idle", bus.busy, 0);
        wait_clks(2);
        check("t4_rd_cnt", rd_pulses - snap_rd, 0);
        check("t4_cnt", bus.rd_cmd_cnt, 2);
        spi_read(24'h000004, 1);
        check("t4_b0", rx_buf[0], 8'h3C);
        check("t4_cnt2", bus.rd_cmd_cnt, 3);
        end_tx();

        // Three-byte continuous stream at clock/8 starting at 0x011
        spi_read(24'h000011, 3);
        check("t6_b0", rx_buf[0], 8'hAD);
        check("t6_b1", rx_buf[1], 8'hBE);
        check("t6_b2", rx_buf[2], 8'hEF);
        end_tx();

        // Reset during the third data byte (0xBE = 1011_1110)
        spi_read(24'h000010, 2);
        for (int i = 7; i >= 4; i--) begin
            spi_bit(1'b0, miso);
            check("t5_bit", miso, (i == 6) ? 32'd0 : 32'd1);
        end
        wait_clks(4);
        check("t5_pre_oe",  bus.flash_io1_oe, 1);
        check("t5_pre_io1", bus.flash_io1, 1);
        rst = 1'b1;
        #1;
        check("t5_oe",   bus.flash_io1_oe, 0);
        check("t5_busy", bus.busy, 0);
        check("t5_io1",  bus.flash_io1, 0);
        check("t5_cnt0", bus.rd_cmd_cnt, 0);
        bus.flash_csb = 1'b1;
        bus.flash_clk = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(3);
        spi_read(24'h000020, 1);
        check("t5_b0",  rx_buf[0], 8'h77);
        check("t5_cnt", bus.rd_cmd_cnt, 1);
        end_tx();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
